// File: rtl/uart_tx_frame_if.sv
// Parallel-side bus of the UART transmit framer.
//   p_data      : byte to transmit (master -> slave)
//   data_valid  : p_data is valid this cycle (master -> slave)
//   in_ready    : framer holding register is empty (slave -> master)
//   par_en      : insert a parity bit into the frame (master -> slave)
//   parity_type : 1 = even, 0 = odd (master -> slave)
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  in_ready;
  logic                  par_en;
  logic                  parity_type;

  modport master (
    output p_data,
    output data_valid,
    output par_en,
    output parity_type,
    input  in_ready
  );

  modport slave (
    input  p_data,
    input  data_valid,
    input  par_en,
    input  parity_type,
    output in_ready
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit framer, one bit per clk2 cycle.
// A byte is accepted into a one-entry holding register over a valid/ready
// handshake, then sent as start bit, DATA_WIDTH data bits LSB first, an
// optional parity bit and one stop bit. A held byte is loaded on the last
// stop cycle so consecutive frames run with no idle gap.
// Ports:
//   clk2   : bit clock, rising edge
//   rst    : asynchronous, active-low reset
//   bus    : slave side of uart_tx_frame_if (p_data, data_valid, in_ready,
//            par_en, parity_type)
//   tx_out : serial line, idles high
//   busy   : a frame is in progress
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int EVEN       = 1
) (
  input  logic              clk2,
  input  logic              rst,
  uart_tx_frame_if.slave    bus,
  output logic              tx_out,
  output logic              busy
);

  localparam int   CNT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic L_EVEN = 1'(EVEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_tx_nxt;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_hold_vld;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  w_load;
  logic                  w_accept;
  logic                  w_last_bit;

  // Matches the RX checker: even -> XOR of the data, odd -> its inverse.
  function automatic logic parity_of(input logic [DATA_WIDTH-1:0] data,
                                     input logic                  ptype);
    return (ptype == L_EVEN) ? ^data : ~^data;
  endfunction

  assign bus.in_ready = ~r_hold_vld;
  // No bypass: a byte is only taken while the holding register is empty,
  // so accept and load can never fall on the same edge.
  assign w_accept     = bus.data_valid & ~r_hold_vld;
  // STOP lasts one cycle, so being in STOP means this is its last cycle.
  assign w_load       = r_hold_vld & ((r_state == S_IDLE) | (r_state == S_STOP));
  assign w_last_bit   = (r_cnt == CNT_W'(DATA_WIDTH - 1));

  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // tx_out is registered, so the value computed here is the line level for
  // the state being entered.
  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_load) begin
          w_state_nxt = S_START;
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        w_state_nxt = S_DATA;
        w_tx_nxt    = r_shift[0];
      end
      S_DATA: begin
        if (!w_last_bit) begin
          w_tx_nxt = r_shift[0];
        end else if (r_par_en) begin
          w_state_nxt = S_PARITY;
          w_tx_nxt    = r_par_bit;
        end else begin
          w_state_nxt = S_STOP;
        end
      end
      S_PARITY: begin
        w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_load) begin
          w_state_nxt = S_START;
          w_tx_nxt    = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
    end else if (w_accept) begin
      r_hold     <= bus.p_data;
      r_hold_vld <= 1'b1;
    end else if (w_load) begin
      r_hold_vld <= 1'b0;
    end
  end

  // Frame configuration is captured at load so mid-frame changes of
  // par_en/parity_type only affect the next frame.
  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      r_shift   <= '0;
      r_cnt     <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
    end else if (w_load) begin
      r_shift   <= r_hold;
      r_par_en  <= bus.par_en;
      r_par_bit <= parity_of(r_hold, bus.parity_type);
    end else if (r_state == S_START) begin
      r_shift <= r_shift >> 1;
      r_cnt   <= '0;
    end else if (r_state == S_DATA) begin
      r_shift <= r_shift >> 1;
      if (!w_last_bit) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      tx_out <= 1'b1;
      busy   <= 1'b0;
    end else begin
      tx_out <= w_tx_nxt;
      busy   <= (w_state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;

  typedef bit bitq_t[$];

  logic clk2;
  logic rst;
  logic tx_out;
  logic busy;
  int   total;
  int   bad;

  uart_tx_frame_if #(.DATA_WIDTH(8)) ifc ();

  uart_tx_frame #(.DATA_WIDTH(8), .EVEN(1)) dut (
    .clk2   (clk2),
    .rst    (rst),
    .bus    (ifc.slave),
    .tx_out (tx_out),
    .busy   (busy)
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  task automatic tick();
    @(posedge clk2);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line levels for one frame, from the framing rules: start 0,
  // data LSB first, optional parity making the count of ones even (even)
  // or odd (odd), stop 1.
  function automatic bitq_t mk_frame(input logic [7:0] b, input bit pe, input bit pt);
    bitq_t q;
    int    ones;
    ones = $countones(b);
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(b[i]);
    if (pe) q.push_back(pt ? bit'(ones % 2) : bit'((ones + 1) % 2));
    q.push_back(1'b1);
    return q;
  endfunction

  // Present one byte with the framer idle, then follow the whole frame.
  // par_en/parity_type are scrambled after the load edge to show they are
  // latched per frame.
  task automatic send(input logic [7:0] b, input bit pe, input bit pt);
    bitq_t f;
    bit    obs[$];
    int    ones;
    f = mk_frame(b, pe, pt);
    ifc.p_data      = b;
    ifc.data_valid  = 1'b1;
    ifc.par_en      = pe;
    ifc.parity_type = pt;
    tick();
    ifc.data_valid = 1'b0;
    ifc.p_data     = 8'($urandom);
    chk("accept_rdy", 32'(ifc.in_ready), 32'd0);
    chk("accept_tx", 32'(tx_out), 32'd1);
    chk("accept_busy", 32'(busy), 32'd0);
    for (int k = 0; k < f.size(); k++) begin
      tick();
      ifc.par_en      = 1'($urandom);
      ifc.parity_type = 1'($urandom);
      chk($sformatf("frm_%02h_b%0d", b, k), 32'(tx_out), 32'(f[k]));
      chk($sformatf("frm_%02h_busy%0d", b, k), 32'(busy), 32'd1);
      obs.push_back(tx_out);
    end
    tick();
    chk($sformatf("end_%02h_tx", b), 32'(tx_out), 32'd1);
    chk($sformatf("end_%02h_busy", b), 32'(busy), 32'd0);
    chk($sformatf("end_%02h_rdy", b), 32'(ifc.in_ready), 32'd1);
    if (pe) begin
      // RX-side view: data bits plus received parity must satisfy the
      // selected parity, i.e. par_err = 0.
      ones = 0;
      for (int i = 1; i <= 9; i++) ones += int'(obs[i]);
      chk($sformatf("rx_par_err_%02h", b), 32'((ones % 2) != (pt ? 0 : 1)), 32'd0);
    end
  endtask

  initial begin
    bitq_t exp_q;
    total = 0;
    bad   = 0;
    rst             = 1'b0;
    ifc.p_data      = 8'h00;
    ifc.data_valid  = 1'b0;
    ifc.par_en      = 1'b0;
    ifc.parity_type = 1'b0;

    // Reset held, then idle.
    repeat (3) tick();
    chk("rst_tx", 32'(tx_out), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdy", 32'(ifc.in_ready), 32'd1);
    #3 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_tx", 32'(tx_out), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_rdy", 32'(ifc.in_ready), 32'd1);
    end

    // Directed frames.
    send(8'hA5, 1'b1, 1'b1);
    send(8'h07, 1'b1, 1'b1);
    send(8'h07, 1'b1, 1'b0);
    send(8'hFF, 1'b0, 1'b1);

    // Back-to-back: data_valid held high across both bytes.
    exp_q = mk_frame(8'h55, 1'b1, 1'b0);
    begin
      bitq_t f2;
      f2 = mk_frame(8'h3C, 1'b1, 1'b0);
      foreach (f2[i]) exp_q.push_back(f2[i]);
    end
    ifc.p_data      = 8'h55;
    ifc.data_valid  = 1'b1;
    ifc.par_en      = 1'b1;
    ifc.parity_type = 1'b0;
    tick();
    ifc.p_data = 8'h3C;
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (k == 2) ifc.data_valid = 1'b0;
      chk($sformatf("b2b_tx%0d", k), 32'(tx_out), 32'(exp_q[k-1]));
      chk($sformatf("b2b_busy%0d", k), 32'(busy), 32'd1);
      chk($sformatf("b2b_rdy%0d", k), 32'(ifc.in_ready), 32'((k == 1) || (k >= 12)));
    end
    tick();
    chk("b2b_end_tx", 32'(tx_out), 32'd1);
    chk("b2b_end_busy", 32'(busy), 32'd0);

    // Reset during data bit 4 of 0xA5 with a second byte held.
    ifc.p_data      = 8'hA5;
    ifc.data_valid  = 1'b1;
    ifc.par_en      = 1'b1;
    ifc.parity_type = 1'b1;
    tick();
    ifc.data_valid = 1'b0;
    tick();
    ifc.p_data     = 8'h81;
    ifc.data_valid = 1'b1;
    tick();
    ifc.data_valid = 1'b0;
    chk("rst2_held", 32'(ifc.in_ready), 32'd0);
    repeat (3) tick();
    chk("rst2_bit4", 32'(tx_out), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("rst2_tx", 32'(tx_out), 32'd1);
    chk("rst2_rdy", 32'(ifc.in_ready), 32'd1);
    chk("rst2_busy", 32'(busy), 32'd0);
    tick();
    tick();
    #3 rst = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("post_rst_tx", 32'(tx_out), 32'd1);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    send(8'h3A, 1'b1, 1'b0);

    // Randomized frames.
    for (int n = 0; n < 12; n++) begin
      send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmit framer. It accepts parallel bytes through a valid/ready handshake into a one-entry holding register, then serializes each byte as start bit, 8 data bits LSB first, an optional parity bit and one stop bit on tx_out. It runs at one bit per clk2 cycle, so clk2 is the baud clock. Its parity convention matches the RX-side parity checker: even gives parity bit = ^data, odd gives parity bit = ~^data.

Parameters:
DATA_WIDTH, 8, number of data bits per frame. The frame bit counter is sized to hold DATA_WIDTH-1.
EVEN, 1, parity_type encoding for even parity. Any other value selects odd.

Ports:
clk2  input  1  bit clock, rising edge
rst  input  1  asynchronous, active-low reset
p_data  input  DATA_WIDTH  byte to transmit
data_valid  input  1  p_data is valid this cycle
in_ready  output  1  holding register is empty, so a byte can be accepted
par_en  input  1  1 = insert a parity bit
parity_type  input  1  1 = even, 0 = odd
tx_out  output  1  serial line, idles high
busy  output  1  a frame is in progress (state != IDLE)

Behaviour:
- Reset (rst low, asynchronous):
  - tx_out=1, busy=0, in_ready=1.
  - Holding register empty, shift register and bit counter cleared, state=IDLE.
  - A reset mid-frame aborts the frame immediately, drives tx_out high, and discards any held byte.
- Input handshake:
  - in_ready = ~hold_valid, a registered flag.
  - A byte is accepted at a clk2 edge where data_valid and in_ready are both 1. p_data is captured and hold_valid is set.
  - There is no bypass. If the holding register drains on the same edge, in_ready was already 0, so data_valid is ignored that edge.
- Frame load:
  - Happens when the FSM is in IDLE, or in STOP on its last cycle, and hold_valid=1.
  - At that edge: shift register <= hold, hold_valid <= 0, par_en and parity_type are latched, and the parity bit is computed from the held byte.
  - Changes to par_en or parity_type mid-frame have no effect on the current frame.
- FSM (all outputs registered; each state lasts the stated number of clk2 cycles):
  - IDLE: tx_out=1. Goes to START on the load condition.
  - START: 1 cycle, tx_out=0. Then DATA with bit counter = 0.
  - DATA: DATA_WIDTH cycles. tx_out = shift[0], then shift right and increment the counter. After bit DATA_WIDTH-1, goes to PARITY if the latched par_en=1, else STOP.
  - PARITY: 1 cycle, tx_out = latched parity bit. Then STOP.
  - STOP: 1 cycle, tx_out=1. Goes to START if hold_valid (back-to-back, no idle cycle), else IDLE.
- Timing:
  - Byte accepted at edge N with FSM idle: load at edge N+1, start bit on tx_out from edge N+1.
  - Frame length is 11 cycles with parity, 10 cycles without.
- busy: 1 from the edge entering START until the edge returning to IDLE. It stays 1 continuously across back-to-back frames.
- Throughput: one byte can be held while another is shifting, giving continuous back-to-back frames with no idle gap.

Test Plan:
- Reset then idle for 5 cycles -> tx_out=1, busy=0, in_ready=1 throughout.
- 0xA5, par_en=1, parity_type=1 -> tx_out sequence 0,1,0,1,0,0,1,0,1,0,1 (start, LSB-first data, parity 0, stop). busy high for exactly 11 cycles.
- 0x07, par_en=1 -> parity bit 1 with parity_type=1, parity bit 0 with parity_type=0. Feeding each frame to the RX parity checker gives par_err=0.
- 0xFF, par_en=0 -> 10-cycle frame 0,1,1,1,1,1,1,1,1,1. No parity slot.
- Back-to-back: 0x55 then 0x3C presented with data_valid held high -> 0x3C accepted once in_ready returns high. Its start bit immediately follows 0x55's stop bit, busy never drops, and in_ready=0 while held.
- Assert rst low during data bit 4 of 0xA5 with a second byte held -> tx_out=1 and in_ready=1 immediately. After release the next accepted byte transmits a clean frame and the held byte is never sent.
